// File: rtl/pcie_scr_pkg.sv
// Shared constants, FSM states and LFSR helpers for the PCIe Gen1/Gen2 transmit scrambler.
package pcie_scr_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] K_STP = 8'hFB;

  // Galois feedback for X^16+X^5+X^4+X^3+1
  localparam logic [15:0] LFSR_TAPS = 16'h0039;

  typedef enum logic [1:0] {LINK, OS_FIRST, TS_BODY} scr_state_e;

  function automatic logic [15:0] lfsr_next8(input logic [15:0] state16);
    logic [15:0] v;
    v = state16;
    for (int i = 0; i < 8; i++) begin
      v = {v[14:0], 1'b0} ^ (v[15] ? LFSR_TAPS : 16'h0000);
    end
    return v;
  endfunction

  // Bit i of the byte is the MSB seen before shift i, so the LSB leaves first
  function automatic logic [7:0] lfsr_byte(input logic [15:0] state16);
    logic [15:0] v;
    logic [7:0]  b;
    v = state16;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b[i] = v[15];
      v    = {v[14:0], 1'b0} ^ (v[15] ? LFSR_TAPS : 16'h0000);
    end
    return b;
  endfunction

endpackage

// File: rtl/pcie_scramble_ctrl_lfsr.sv
// Scrambler LFSR register: reseed or advance eight bit-times per symbol.
module pcie_lfsr8_step
  import pcie_scr_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        system_reset,
  input  logic        seed_load,
  input  logic        advance,
  output logic [15:0] value,
  output logic [7:0]  scr_byte
);

  always_ff @(posedge clk_i or negedge system_reset) begin
    if (!system_reset) begin
      value <= SEED;
    end else if (seed_load) begin
      value <= SEED;
    end else if (advance) begin
      value <= lfsr_next8(value);
    end
  end

  assign scr_byte = lfsr_byte(value);

endmodule

// File: rtl/pcie_scramble_ctrl.sv
// Symbol-rate scrambler sequencer: decides reseed/advance/hold and XOR per symbol,
// keeping TS1/TS2 bodies unscrambled. One registered output stage.
module pcie_scramble_ctrl
  import pcie_scr_pkg::*;
#(
  parameter logic [15:0] SEED   = 16'hFFFF,
  parameter int          TS_LEN = 16
) (
  input  logic        clk_i,
  input  logic        system_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_k,
  input  logic        scramble_dis,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_k,
  output logic        os_active,
  output logic [15:0] lfsr_state
);

  localparam int CNT_W = $clog2(TS_LEN);

  scr_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, is_com, is_skp, is_fts_idl;
  logic             seed_load, advance, scramble, os_nxt, link_rules;
  logic [7:0]       scr_byte;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign is_com     = in_k && (in_data == K_COM);
  assign is_skp     = in_k && (in_data == K_SKP);
  assign is_fts_idl = in_k && ((in_data == K_FTS) || (in_data == K_IDL));

  pcie_lfsr8_step #(.SEED(SEED)) u_lfsr (
    .clk_i        (clk_i),
    .system_reset (system_reset),
    .seed_load    (seed_load),
    .advance      (advance),
    .value        (lfsr_state),
    .scr_byte     (scr_byte)
  );

  always_ff @(posedge clk_i or negedge system_reset) begin
    if (!system_reset) begin
      state <= LINK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    seed_load  = 1'b0;
    advance    = 1'b0;
    scramble   = 1'b0;
    os_nxt     = 1'b0;
    link_rules = 1'b0;
    if (accept) begin
      if (is_com) begin
        seed_load = 1'b1;
        state_nxt = OS_FIRST;
      end else begin
        case (state)
          LINK: link_rules = 1'b1;
          OS_FIRST: begin
            if (is_skp || is_fts_idl) begin
              link_rules = 1'b1;
              state_nxt  = LINK;
            end else begin
              // first symbol after COM that is not SKP/FTS/IDL opens a TS body
              advance   = 1'b1;
              os_nxt    = 1'b1;
              cnt_nxt   = CNT_W'(TS_LEN - 2);
              state_nxt = TS_BODY;
            end
          end
          TS_BODY: begin
            advance = !is_skp;
            os_nxt  = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = LINK;
          end
          default: state_nxt = LINK;
        endcase
        if (link_rules) begin
          advance  = !is_skp;
          scramble = !in_k && !scramble_dis;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge system_reset) begin
    if (!system_reset) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_k     <= 1'b0;
      os_active <= 1'b0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (accept) begin
        out_data  <= scramble ? (in_data ^ scr_byte) : in_data;
        out_k     <= in_k;
        os_active <= os_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pcie_scramble_ctrl.sv
// Directed bench for pcie_scramble_ctrl: per-cycle comparison against a symbol-level
// model plus literal checks of the transferred symbol stream.
module tb_pcie_scramble_ctrl;
  import pcie_scr_pkg::*;

  localparam logic [15:0] SEED   = 16'hFFFF;
  localparam int          TS_LEN = 16;

  logic        clk_i = 1'b0;
  logic        system_reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_k = 1'b0;
  logic        scramble_dis = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_k;
  logic        os_active;
  logic [15:0] lfsr_state;

  int vec  = 0;
  int miss = 0;

  // model: output register contents and scrambler position
  logic [15:0] m_lfsr = SEED;
  logic        m_ov = 1'b0, m_ok = 1'b0, m_os = 1'b0;
  logic [7:0]  m_od = 8'h00;
  logic        m_after_com = 1'b0;
  int          m_body_left = 0;

  logic [9:0]  xfer_q[$];

  pcie_scramble_ctrl #(.SEED(SEED), .TS_LEN(TS_LEN)) dut (
    .clk_i        (clk_i),
    .system_reset (system_reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_k         (in_k),
    .scramble_dis (scramble_dis),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_k        (out_k),
    .os_active    (os_active),
    .lfsr_state   (lfsr_state)
  );

  always #5 clk_i = ~clk_i;

  // scrambler as polynomial division: shift left, reduce by G(X) when X^16 appears
  task automatic m_advance(output logic [7:0] sb);
    logic [16:0] r;
    r = {1'b0, m_lfsr};
    for (int i = 0; i < 8; i++) begin
      sb[i] = r[15];
      r = r << 1;
      if (r[16]) r = r ^ 17'h10039;
    end
    m_lfsr = r[15:0];
  endtask

  task automatic m_symbol(input logic [7:0] d, input logic k, input logic dis);
    logic [7:0] sb;
    logic com, skp;
    com  = k && d == 8'hBC;
    skp  = k && d == 8'h1C;
    m_od = d;
    m_ok = k;
    m_os = 1'b0;
    if (com) begin
      m_lfsr = SEED;
      m_after_com = 1'b1;
      m_body_left = 0;
    end else if (m_body_left > 0) begin
      m_os = 1'b1;
      if (!skp) m_advance(sb);
      m_body_left--;
    end else if (m_after_com && !(k && (d == 8'h1C || d == 8'h3C || d == 8'h7C))) begin
      m_os = 1'b1;
      m_advance(sb);
      m_body_left = TS_LEN - 2;
      m_after_com = 1'b0;
    end else begin
      m_after_com = 1'b0;
      if (!skp) begin
        m_advance(sb);
        if (!k && !dis) m_od = d ^ sb;
      end
    end
  endtask

  always @(posedge clk_i or negedge system_reset) begin
    if (!system_reset) begin
      m_lfsr = SEED; m_ov = 1'b0; m_od = 8'h00; m_ok = 1'b0; m_os = 1'b0;
      m_after_com = 1'b0; m_body_left = 0;
    end else if (!m_ov || out_ready) begin
      if (in_valid) m_symbol(in_data, in_k, scramble_dis);
      m_ov = in_valid;
    end
  end

  always @(posedge clk_i)
    if (system_reset && out_valid && out_ready) xfer_q.push_back({os_active, out_k, out_data});

  always @(negedge clk_i) begin
    vec++;
    if ({out_valid, in_ready, out_data, out_k, os_active, lfsr_state} !==
        {m_ov, (!m_ov || out_ready), m_od, m_ok, m_os, m_lfsr}) begin
      miss++;
      $display("FAIL cycle_cmp t=%0t got v=%b r=%b d=%h k=%b os=%b lfsr=%h expected v=%b r=%b d=%h k=%b os=%b lfsr=%h",
               $time, out_valid, in_ready, out_data, out_k, os_active, lfsr_state,
               m_ov, (!m_ov || out_ready), m_od, m_ok, m_os, m_lfsr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic k);
    logic acc;
    int   n;
    in_valid = 1'b1; in_data = d; in_k = k;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk_i); acc = in_ready;
      @(posedge clk_i); #1; n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic com_skp3();
    send(K_COM, 1'b1);
    repeat (3) send(K_SKP, 1'b1);
  endtask

  initial begin
    int os_cnt;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_lfsr", 32'(lfsr_state), 32'hFFFF);
    chk("rst_out_data", {23'd0, os_active, out_data}, 32'd0);
    system_reset = 1'b1;

    // 1: reseed, SKPs hold, then the first four scramble bytes
    com_skp3();
    chk("t1_lfsr_after_skp", 32'(lfsr_state), 32'hFFFF);
    repeat (4) send(8'h00, 1'b0);
    drain();
    chk("t1_len", xfer_q.size(), 8);
    chk("t1_com", 32'(xfer_q[0]), 32'h1BC);
    chk("t1_skp", 32'(xfer_q[3]), 32'h11C);
    chk("t1_d0", 32'(xfer_q[4]), 32'hFF);
    chk("t1_d1", 32'(xfer_q[5]), 32'h17);
    chk("t1_d2", 32'(xfer_q[6]), 32'hC0);
    chk("t1_d3", 32'(xfer_q[7]), 32'h14);
    xfer_q.delete();

    // 2: TS body passes unscrambled, following data uses byte 15
    send(K_COM, 1'b1);
    send(K_PAD, 1'b1);
    repeat (14) send(8'h4A, 1'b0);
    send(8'h00, 1'b0);
    drain();
    chk("t2_len", xfer_q.size(), 17);
    chk("t2_pad", 32'(xfer_q[1]), 32'h3F7);
    chk("t2_body_first", 32'(xfer_q[2]), 32'h24A);
    chk("t2_body_last", 32'(xfer_q[15]), 32'h24A);
    chk("t2_after_body", 32'(xfer_q[16]), 32'h08D);
    os_cnt = 0;
    foreach (xfer_q[i]) if (xfer_q[i][9]) os_cnt++;
    chk("t2_os_count", os_cnt, 15);
    xfer_q.delete();

    // 3: scramble_dis bypasses XOR only
    scramble_dis = 1'b1;
    com_skp3();
    repeat (4) send(8'h00, 1'b0);
    scramble_dis = 1'b0;
    com_skp3();
    send(8'h00, 1'b0);
    drain();
    chk("t3_len", xfer_q.size(), 13);
    chk("t3_dis0", 32'(xfer_q[4]), 32'h00);
    chk("t3_dis3", 32'(xfer_q[7]), 32'h00);
    chk("t3_en", 32'(xfer_q[12]), 32'hFF);
    xfer_q.delete();

    // 4: three stalled cycles with a symbol waiting
    com_skp3();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h00; in_k = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t4_in_ready", 32'(in_ready), 32'd0);
      chk("t4_hold_data", 32'(out_data), 32'h17);
      chk("t4_hold_lfsr", 32'(lfsr_state), 32'h0328);
    end
    @(posedge clk_i); #1;
    out_ready = 1'b1;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    drain();
    chk("t4_len", xfer_q.size(), 8);
    chk("t4_d1", 32'(xfer_q[5]), 32'h17);
    chk("t4_d2", 32'(xfer_q[6]), 32'hC0);
    chk("t4_d3", 32'(xfer_q[7]), 32'h14);
    xfer_q.delete();

    // 5: reset in the middle of a TS body
    send(K_COM, 1'b1);
    send(K_PAD, 1'b1);
    repeat (4) send(8'h4A, 1'b0);
    system_reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_lfsr", 32'(lfsr_state), 32'hFFFF);
    chk("t5_rst_os", 32'(os_active), 32'd0);
    @(posedge clk_i); #1;
    system_reset = 1'b1;
    xfer_q.delete();
    send(8'h00, 1'b0);
    drain();
    chk("t5_len", xfer_q.size(), 1);
    chk("t5_d0", 32'(xfer_q[0]), 32'hFF);
    xfer_q.delete();

    // 6: STP is passed through but advances the LFSR
    com_skp3();
    send(K_STP, 1'b1);
    send(8'h00, 1'b0);
    drain();
    chk("t6_len", xfer_q.size(), 6);
    chk("t6_stp", 32'(xfer_q[4]), 32'h1FB);
    chk("t6_d0", 32'(xfer_q[5]), 32'h17);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1);
  end

endmodule
